// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the cyc/we/adr/dat/ack memory bus.
package mem_bus_pkg;

  localparam int DAT_W_DEF = 32;
  localparam int ADR_W_DEF = 16;
  localparam int LAT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response signal bundle between the cache controller (master) and the memory responder (slave).
interface mem_responder_if
  import mem_bus_pkg::*;
#(
  parameter int DAT_W = DAT_W_DEF,
  parameter int ADR_W = ADR_W_DEF
);

  logic             cyc_m2s;
  logic             we_m2s;
  logic [ADR_W-1:0] adr_m2s;
  logic [DAT_W-1:0] dat_m2s;
  logic [DAT_W-1:0] dat_s2m;
  logic             ack_s2m;
  logic             err_s2m;

  modport master (
    output cyc_m2s, we_m2s, adr_m2s, dat_m2s,
    input  dat_s2m, ack_s2m, err_s2m
  );

  modport slave (
    input  cyc_m2s, we_m2s, adr_m2s, dat_m2s,
    output dat_s2m, ack_s2m, err_s2m
  );

endinterface

// File: rtl/mem_responder_sp_ram.sv
// Single-port RAM with synchronous write and registered read; contents are never reset.
module sp_ram #(
  parameter int DEPTH = 1024,
  parameter int DAT_W = 32,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [DAT_W-1:0] wdata_i,
  output logic [DAT_W-1:0] rdata_o
);

  logic [DAT_W-1:0] mem_q [DEPTH];
  logic [DAT_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one word per transaction, fixed wait states, then a single ack or err pulse.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DAT_W   = DAT_W_DEF,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DAT_W-1:0]     wdat_q, wdat_d;
  logic [DAT_W-1:0]     rsp_dat_q, rsp_dat_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 in_range;
  logic                 ram_we;
  logic [IDX_W-1:0]     ram_idx;
  logic [DAT_W-1:0]     ram_rdata;

  assign in_range = {1'b0, adr_q} < (ADR_W + 1)'(DEPTH);

  // The RAM reads every cycle; in IDLE it follows the live bus address so a
  // LATENCY=1 read already has its data registered by the ack edge.
  assign ram_idx = (state_q == IDLE) ? bus.adr_m2s[IDX_W-1:0] : adr_q[IDX_W-1:0];

  sp_ram #(
    .DEPTH (DEPTH),
    .DAT_W (DAT_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_idx),
    .wdata_i (wdat_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rsp_dat_d = rsp_dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cyc_m2s) begin
          we_d    = bus.we_m2s;
          adr_d   = bus.adr_m2s;
          wdat_d  = bus.dat_m2s;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.cyc_m2s) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end else if (in_range) begin
          ram_we    = we_q;
          ack_d     = 1'b1;
          rsp_dat_d = we_q ? wdat_q : ram_rdata;
          state_d   = RESP;
        end else begin
          err_d     = 1'b1;
          rsp_dat_d = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_dat_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rsp_dat_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rsp_dat_q <= rsp_dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack_s2m = ack_q;
  assign bus.err_s2m = err_q;
  assign bus.dat_s2m = rsp_dat_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=3 and a LATENCY=1 instance share one driver and one monitor.
module tb_mem_responder;
  import mem_bus_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct {
    int          expCycle;
    bit          isErr;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cycDrv = 1'b0;
  logic        weDrv = 1'b0;
  logic [15:0] adrDrv = '0;
  logic [31:0] datDrv = '0;

  int          cycleCnt = 0;
  int          total = 0;
  int          bad = 0;
  resp_t       expQ[$];
  logic [31:0] refMem[int];

  logic        ackSel, errSel, ackOther, errOther;
  logic [31:0] datSel;

  always #5 clk = ~clk;

  mem_responder_if #(.DAT_W(32), .ADR_W(16)) bus3();
  mem_responder_if #(.DAT_W(32), .ADR_W(16)) bus1();

  mem_responder #(.DAT_W(32), .ADR_W(16), .DEPTH(DEPTH), .LATENCY(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  mem_responder #(.DAT_W(32), .ADR_W(16), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  assign bus3.cyc_m2s = cycDrv & ~sel;
  assign bus1.cyc_m2s = cycDrv & sel;
  assign bus3.we_m2s  = weDrv;
  assign bus1.we_m2s  = weDrv;
  assign bus3.adr_m2s = adrDrv;
  assign bus1.adr_m2s = adrDrv;
  assign bus3.dat_m2s = datDrv;
  assign bus1.dat_m2s = datDrv;

  assign ackSel   = sel ? bus1.ack_s2m : bus3.ack_s2m;
  assign errSel   = sel ? bus1.err_s2m : bus3.err_s2m;
  assign datSel   = sel ? bus1.dat_s2m : bus3.dat_s2m;
  assign ackOther = sel ? bus3.ack_s2m : bus1.ack_s2m;
  assign errOther = sel ? bus3.err_s2m : bus1.err_s2m;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Issue one transaction; the expected response is derived from a plain
  // array model of memory and the ack is due LATENCY edges after sampling.
  task automatic applyStimulus(input bit we, input logic [15:0] adr, input logic [31:0] dat, input bit holdCyc);
    resp_t e;
    int    key;
    int    lat;
    bit    seen;
    lat = sel ? 1 : 3;
    key = (sel ? 65536 : 0) + int'(adr);
    e.expCycle = cycleCnt + (cycDrv ? 2 : 1) + lat;
    if (int'(adr) >= DEPTH) begin
      e.isErr = 1'b1;
      e.data  = '0;
    end else if (we) begin
      e.isErr = 1'b0;
      e.data  = dat;
      refMem[key] = dat;
    end else begin
      e.isErr = 1'b0;
      e.data  = refMem.exists(key) ? refMem[key] : 32'h0;
    end
    weDrv  = we;
    adrDrv = adr;
    datDrv = dat;
    cycDrv = 1'b1;
    expQ.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ackSel || errSel) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL resp_timeout: got no ack/err required one for adr 0x%04h", adr);
    end
    if (!holdCyc) begin
      cycDrv = 1'b0;
      @(negedge clk);
    end
  endtask

  // Monitor: every response pulse is matched against the head of the queue.
  always @(posedge clk) begin
    resp_t e;
    #1;
    if (!rst) begin
      if (ackOther || errOther) begin
        total++;
        bad++;
        $display("[TB] FAIL idle_dut_resp: got ack=%0b err=%0b required 0/0", ackOther, errOther);
      end
      if (ackSel || errSel) begin
        checkOutput("ack_err_exclusive", 32'(ackSel & errSel), 32'h0);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: got ack=%0b err=%0b required none", ackSel, errSel);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_cycle", 32'(cycleCnt), 32'(e.expCycle));
          checkOutput("err_flag", 32'(errSel), 32'(e.isErr));
          checkOutput("ack_flag", 32'(ackSel), 32'(!e.isErr));
          checkOutput("resp_data", datSel, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] adr;
    bit          we;
    bit          hold;
    int          key;

    repeat (3) @(negedge clk);
    checkOutput("reset_ack3", 32'(bus3.ack_s2m), 32'h0);
    checkOutput("reset_err3", 32'(bus3.err_s2m), 32'h0);
    checkOutput("reset_dat3", bus3.dat_s2m, 32'h0);
    checkOutput("reset_ack1", 32'(bus1.ack_s2m), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sel = 1'b0;
    applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 16'h0010, 32'h0, 1'b0);

    applyStimulus(1'b1, 16'h0000, 32'hCAFE0000, 1'b0);
    applyStimulus(1'b0, 16'h0400, 32'h0, 1'b0);
    applyStimulus(1'b1, 16'h0400, 32'h00000001, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 32'h00000002, 1'b0);
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0);

    applyStimulus(1'b1, 16'h0020, 32'h12345678, 1'b0);
    weDrv  = 1'b1;
    adrDrv = 16'h0020;
    datDrv = 32'h00000055;
    cycDrv = 1'b1;
    repeat (2) @(negedge clk);
    cycDrv = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 16'h0020, 32'h0, 1'b0);

    applyStimulus(1'b1, 16'h0030, 32'h30303030, 1'b0);
    applyStimulus(1'b0, 16'h0030, 32'h0, 1'b1);
    applyStimulus(1'b1, 16'h0040, 32'h000000A5, 1'b0);
    applyStimulus(1'b0, 16'h0040, 32'h0, 1'b0);

    applyStimulus(1'b1, 16'h0050, 32'h11111111, 1'b0);
    weDrv  = 1'b1;
    adrDrv = 16'h0050;
    datDrv = 32'h00000077;
    cycDrv = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    cycDrv = 1'b0;
    #1;
    checkOutput("midreset_ack", 32'(bus3.ack_s2m), 32'h0);
    checkOutput("midreset_err", 32'(bus3.err_s2m), 32'h0);
    checkOutput("midreset_dat", bus3.dat_s2m, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 16'h0050, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      adr  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 31));
      key  = int'(adr);
      hold = (i != 39) && ($urandom_range(0, 3) == 0);
      if (!we && key < DEPTH && !refMem.exists(key)) we = 1'b1;
      applyStimulus(we, adr, $urandom, hold);
    end

    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      adr  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, DEPTH - 1)) : 16'($urandom_range(0, 31));
      key  = 65536 + int'(adr);
      hold = (i != 149) && ($urandom_range(0, 3) == 0);
      if (!we && !refMem.exists(key)) we = 1'b1;
      applyStimulus(we, adr, $urandom, hold);
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
